// File: rtl/serial_operand_loader.sv
// serial_operand_loader: accepts a parallel operand pair over valid/ready and
// streams both operands LSB-first, one bit of each per transfer, with
// first/last bit markers for a downstream serial adder.
// Optional macro SERIAL_LOADER_PREFETCH_EN adds a one-entry holding register
// so consecutive words stream with no idle bubble between them.
module serial_operand_loader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;

  logic accept;
  logic xfer;
  logic is_last;

`ifdef SERIAL_LOADER_PREFETCH_EN
  logic [WIDTH-1:0] hold_a_q, hold_a_d;
  logic [WIDTH-1:0] hold_b_q, hold_b_d;
  logic             hold_valid_q, hold_valid_d;

  // Ready whenever the holding slot is free; forced low while reset is held.
  assign in_ready = reset & ~hold_valid_q;
`else
  // Ready only between words; forced low while reset is held.
  assign in_ready = reset & (state_q == IDLE);
`endif

  assign accept  = in_valid & in_ready;
  assign xfer    = ser_valid & ser_ready;
  assign is_last = (cnt_q == LAST_CNT);

  // Serial outputs are pure decodes of state, so they hold naturally under stall
  // and drop to 0 the instant reset clears the state register.
  assign ser_valid = (state_q == SHIFT);
  assign busy      = ser_valid;
  assign ser_a     = ser_valid & shift_a_q[0];
  assign ser_b     = ser_valid & shift_b_q[0];
  assign ser_first = ser_valid & (cnt_q == '0);
  assign ser_last  = ser_valid & is_last;

  // Next-state, counter and shift/hold register updates.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
`ifdef SERIAL_LOADER_PREFETCH_EN
    hold_a_d     = hold_a_q;
    hold_b_d     = hold_b_q;
    hold_valid_d = hold_valid_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_a_d = in_a;
          shift_b_d = in_b;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (xfer) begin
          shift_a_d = shift_a_q >> 1;
          shift_b_d = shift_b_q >> 1;
          cnt_d     = cnt_q + CW'(1);
        end
`ifdef SERIAL_LOADER_PREFETCH_EN
        if (xfer && is_last) begin
          cnt_d = '0;
          if (hold_valid_q) begin
            // Drain the holding slot into the shifter; refill it if a pair arrives now.
            shift_a_d    = hold_a_q;
            shift_b_d    = hold_b_q;
            hold_valid_d = accept;
            if (accept) begin
              hold_a_d = in_a;
              hold_b_d = in_b;
            end
          end else if (accept) begin
            // Empty slot at the word boundary: bypass straight into the shifter.
            shift_a_d = in_a;
            shift_b_d = in_b;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          hold_a_d     = in_a;
          hold_b_d     = in_b;
          hold_valid_d = 1'b1;
        end
`else
        if (xfer && is_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_a_q <= '0;
      shift_b_q <= '0;
`ifdef SERIAL_LOADER_PREFETCH_EN
      hold_a_q     <= '0;
      hold_b_q     <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
`ifdef SERIAL_LOADER_PREFETCH_EN
      hold_a_q     <= hold_a_d;
      hold_b_q     <= hold_b_d;
      hold_valid_q <= hold_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_operand_loader.sv
// Directed bench for serial_operand_loader (WIDTH=16).
// Tests specific to SERIAL_LOADER_PREFETCH_EN run only when that macro is defined.
module tb_serial_operand_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        ser_ready;
  logic        ser_valid;
  logic        ser_a;
  logic        ser_b;
  logic        ser_first;
  logic        ser_last;
  logic        busy;

  int total = 0;
  int bad   = 0;

  serial_operand_loader #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ser_ready (ser_ready),
    .ser_valid (ser_valid),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] a, input logic [15:0] b);
    check("send_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  // Check all 16 bits of a word; optionally stall before transferring bit stall_bit.
  task automatic collect_word(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                              input int stall_bit, input int stall_cycles, input int exp_cycles);
    int cycles = 0;
    for (int i = 0; i < 16; i++) begin
      check({tag, "_valid"}, ser_valid, 1);
      check({tag, "_busy"},  busy, 1);
      check({tag, "_a"},     ser_a, ea[i]);
      check({tag, "_b"},     ser_b, eb[i]);
      check({tag, "_first"}, ser_first, (i == 0));
      check({tag, "_last"},  ser_last, (i == 15));
`ifndef SERIAL_LOADER_PREFETCH_EN
      check({tag, "_in_ready"}, in_ready, 0);
`endif
      if (i == stall_bit) begin
        ser_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          step();
          cycles++;
          check({tag, "_stall_valid"}, ser_valid, 1);
          check({tag, "_stall_a"},     ser_a, ea[i]);
          check({tag, "_stall_b"},     ser_b, eb[i]);
          check({tag, "_stall_first"}, ser_first, 0);
          check({tag, "_stall_last"},  ser_last, 0);
        end
        ser_ready = 1'b1;
      end
      step();
      cycles++;
    end
    check({tag, "_cycles"}, cycles, exp_cycles);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    ser_ready = 1'b1;
    reset     = 1'b0;
    #3;
    check("rst_ser_valid", ser_valid, 0);
    check("rst_busy",      busy, 0);
    check("rst_in_ready",  in_ready, 0);
    check("rst_first",     ser_first, 0);
    check("rst_last",      ser_last, 0);
    check("rst_ser_a",     ser_a, 0);
    check("rst_ser_b",     ser_b, 0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_valid",    ser_valid, 0);

    // All-ones word, no back-pressure.
    send_word(16'hFFFF, 16'hFFFF);
    collect_word("ones", 16'hFFFF, 16'hFFFF, -1, 0, 16);
    check("ones_end_valid", ser_valid, 0);
    check("ones_end_ready", in_ready, 1);
    check("ones_end_first", ser_first, 0);

    // Mixed pattern.
    send_word(16'h500A, 16'h400A);
    collect_word("mix", 16'h500A, 16'h400A, -1, 0, 16);
    check("mix_end_valid", ser_valid, 0);

    // Three-cycle stall while bit 4 is presented.
    send_word(16'h1234, 16'hA5C3);
    collect_word("stall", 16'h1234, 16'hA5C3, 4, 3, 19);
    check("stall_end_valid", ser_valid, 0);

    // Asynchronous reset during bit 7.
    send_word(16'hFFFF, 16'h0F0F);
    for (int i = 0; i < 7; i++) step();
    check("pre_rst_a", ser_a, 1);
    check("pre_rst_b", ser_b, 0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid",    ser_valid, 0);
    check("mid_rst_busy",     busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    #10;
    reset = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1);
    check("rel_valid",    ser_valid, 0);
    send_word(16'h8001, 16'h7FFE);
    collect_word("after_rst", 16'h8001, 16'h7FFE, -1, 0, 16);

`ifndef SERIAL_LOADER_PREFETCH_EN
    // in_valid held through SHIFT: no accept until the bubble cycle.
    in_valid = 1'b1;
    in_a     = 16'hC3C3;
    in_b     = 16'h0001;
    step();
    in_a = 16'h5555;
    in_b = 16'hAAAA;
    collect_word("b2b_w1", 16'hC3C3, 16'h0001, -1, 0, 16);
    check("bubble_valid",    ser_valid, 0);
    check("bubble_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    collect_word("b2b_w2", 16'h5555, 16'hAAAA, -1, 0, 16);
    check("b2b_end_valid", ser_valid, 0);
`else
    begin
      logic [15:0] wa [3];
      logic [15:0] wb [3];
      int sent;
      int seen_ready_low;
      int first_cnt;
      int valid_cnt;
      wa[0] = 16'h1111; wb[0] = 16'hF0F0;
      wa[1] = 16'hBEEF; wb[1] = 16'h0000;
      wa[2] = 16'h8421; wb[2] = 16'hFFFF;
      in_valid = 1'b1;
      in_a     = wa[0];
      in_b     = wb[0];
      step();
      sent = 1;
      seen_ready_low = 0;
      first_cnt = 0;
      valid_cnt = 0;
      for (int i = 0; i < 48; i++) begin
        if (sent < 3) begin
          in_valid = 1'b1;
          in_a     = wa[sent];
          in_b     = wb[sent];
        end else begin
          in_valid = 1'b0;
        end
        if (ser_valid) valid_cnt++;
        if (ser_first) first_cnt++;
        if (!in_ready) seen_ready_low = 1;
        check("pf_valid", ser_valid, 1);
        check("pf_a",     ser_a, wa[i / 16][i % 16]);
        check("pf_b",     ser_b, wb[i / 16][i % 16]);
        check("pf_first", ser_first, ((i % 16) == 0));
        check("pf_last",  ser_last, ((i % 16) == 15));
        if (in_valid && in_ready) sent++;
        step();
      end
      in_valid = 1'b0;
      check("pf_valid_cycles", valid_cnt, 48);
      check("pf_first_count",  first_cnt, 3);
      check("pf_ready_low",    seen_ready_low, 1);
      check("pf_end_valid",    ser_valid, 0);
      check("pf_end_ready",    in_ready, 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
